// File: rtl/whac_game_ctrl.sv
// Game-level sequencer for the whack-a-mole core: round control, BCD countdown,
// high-score tracking and the pseudo-random mole position source.
module whac_game_ctrl #(
  parameter int unsigned    TICKS_PER_SEC = 1000000,
  parameter int unsigned    GAME_TENS     = 3,
  parameter int unsigned    GAME_ONES     = 0,
  parameter logic [15:0]    LFSR_SEED     = 16'hACE1
) (
  input  logic       clk_1us,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] score_BCD1,
  input  logic [3:0] score_BCD0,
  output logic       timesup,
  output logic [3:0] random,
  output logic       core_reset_n,
  output logic       playing,
  output logic [3:0] time_BCD1,
  output logic [3:0] time_BCD0,
  output logic [3:0] high_BCD1,
  output logic [3:0] high_BCD0
);

  typedef enum logic [1:0] {IDLE, ARM, PLAY, OVER} state_t;

  localparam logic [19:0] TICK_MAX  = 20'(TICKS_PER_SEC - 1);
  localparam logic [3:0]  LOAD_TENS = 4'(GAME_TENS);
  localparam logic [3:0]  LOAD_ONES = 4'(GAME_ONES);

  state_t      state;
  logic [19:0] tick;
  logic [15:0] lfsr;
  logic        start_q;
  logic        start_pulse;
  logic        lfsr_fb;

  // start_q resets high so a button held through reset cannot start a game.
  assign start_pulse  = start & ~start_q;
  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign random       = lfsr[3:0];
  assign timesup      = (state != PLAY);
  assign playing      = (state == PLAY);
  assign core_reset_n = ~(reset | (state == ARM));

  always_ff @(posedge clk_1us) begin
    if (reset) begin
      state     <= IDLE;
      time_BCD1 <= LOAD_TENS;
      time_BCD0 <= LOAD_ONES;
      tick      <= '0;
      high_BCD1 <= 4'd0;
      high_BCD0 <= 4'd0;
      lfsr      <= LFSR_SEED;
      start_q   <= 1'b1;
    end else begin
      start_q <= start;
      lfsr    <= {lfsr[14:0], lfsr_fb};

      case (state)
        IDLE: begin
          if (start_pulse) state <= ARM;
        end

        ARM: begin
          time_BCD1 <= LOAD_TENS;
          time_BCD0 <= LOAD_ONES;
          tick      <= '0;
          state     <= PLAY;
        end

        // The final second ends the round on the same edge the display hits 00.
        PLAY: begin
          if (tick == TICK_MAX) begin
            tick <= '0;
            if (time_BCD1 == 4'd0 && time_BCD0 == 4'd1) begin
              time_BCD0 <= 4'd0;
              state     <= OVER;
            end else if (time_BCD1 == 4'd0 && time_BCD0 == 4'd0) begin
              state <= OVER;
            end else if (time_BCD0 == 4'd0) begin
              time_BCD0 <= 4'd9;
              time_BCD1 <= time_BCD1 - 4'd1;
            end else begin
              time_BCD0 <= time_BCD0 - 4'd1;
            end
          end else begin
            tick <= tick + 20'd1;
          end
        end

        // Score is frozen here, so plain 8-bit compare of the BCD pair is safe.
        OVER: begin
          time_BCD1 <= 4'd0;
          time_BCD0 <= 4'd0;
          if ({score_BCD1, score_BCD0} > {high_BCD1, high_BCD0}) begin
            high_BCD1 <= score_BCD1;
            high_BCD0 <= score_BCD0;
          end
          if (start_pulse) state <= ARM;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whac_game_ctrl.sv
// Directed self-checking bench for whac_game_ctrl with a short 12-second,
// 4-tick-per-second game.
module tb_whac_game_ctrl;

  logic       clk_1us = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] score_BCD1;
  logic [3:0] score_BCD0;
  logic       timesup;
  logic [3:0] random;
  logic       core_reset_n;
  logic       playing;
  logic [3:0] time_BCD1;
  logic [3:0] time_BCD0;
  logic [3:0] high_BCD1;
  logic [3:0] high_BCD0;

  int checks = 0;
  int errors = 0;

  whac_game_ctrl #(
    .TICKS_PER_SEC(4),
    .GAME_TENS(1),
    .GAME_ONES(2),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_1us(clk_1us),
    .reset(reset),
    .start(start),
    .score_BCD1(score_BCD1),
    .score_BCD0(score_BCD0),
    .timesup(timesup),
    .random(random),
    .core_reset_n(core_reset_n),
    .playing(playing),
    .time_BCD1(time_BCD1),
    .time_BCD0(time_BCD0),
    .high_BCD1(high_BCD1),
    .high_BCD0(high_BCD0)
  );

  always #5 clk_1us = ~clk_1us;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling/driving.
  task automatic step();
    @(posedge clk_1us);
    #1;
  endtask

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic applyStimulus(input logic [7:0] score);
    score_BCD1 = score[7:4];
    score_BCD0 = score[3:0];
  endtask

  // Pulse start from IDLE/OVER and check the one-cycle ARM window.
  task automatic startGame(input logic [7:0] high_exp);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    checkOutput("arm_core_reset_n", 16'(core_reset_n), 16'h0);
    checkOutput("arm_playing", 16'(playing), 16'h0);
    start = 1'b0;
    step();
    checkOutput("play_timesup", 16'(timesup), 16'h0);
    checkOutput("play_core_reset_n", 16'(core_reset_n), 16'h1);
    checkOutput("play_time_load", 16'({time_BCD1, time_BCD0}), 16'h12);
    checkOutput("arm_high_kept", 16'({high_BCD1, high_BCD0}), 16'(high_exp));
  endtask

  // Full countdown from the first PLAY sample; optionally pulses start mid-game.
  task automatic playCountdown(input logic [7:0] score, input int pulse_at);
    applyStimulus(score);
    for (int k = 0; k < 48; k++) begin
      checkOutput("countdown_time", 16'({time_BCD1, time_BCD0}), 16'(toBcd(12 - k / 4)));
      checkOutput("countdown_playing", 16'(playing), 16'h1);
      start = (k == pulse_at);
      step();
    end
    start = 1'b0;
    checkOutput("over_playing", 16'(playing), 16'h0);
    checkOutput("over_timesup", 16'(timesup), 16'h1);
    checkOutput("over_time", 16'({time_BCD1, time_BCD0}), 16'h00);
    step();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    applyStimulus(8'h00);

    // Reset behaviour and LFSR start values.
    #1;
    checkOutput("reset_core_reset_n", 16'(core_reset_n), 16'h0);
    step();
    checkOutput("reset_core_reset_n2", 16'(core_reset_n), 16'h0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("idle_timesup", 16'(timesup), 16'h1);
    checkOutput("idle_playing", 16'(playing), 16'h0);
    checkOutput("idle_time", 16'({time_BCD1, time_BCD0}), 16'h12);
    checkOutput("idle_high", 16'({high_BCD1, high_BCD0}), 16'h00);
    checkOutput("idle_random0", 16'(random), 16'h1);
    checkOutput("idle_core_reset_n", 16'(core_reset_n), 16'h1);
    step();
    checkOutput("idle_random1", 16'(random), 16'h3);

    // Button held through reset must not start a game.
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checkOutput("held_start_idle", 16'(playing), 16'h0);
    checkOutput("held_start_no_arm", 16'(core_reset_n), 16'h1);

    // Game 1: ends at 27, mid-game start pulse ignored.
    startGame(8'h00);
    playCountdown(8'h27, 10);
    checkOutput("high_after_27", 16'({high_BCD1, high_BCD0}), 16'h27);

    // Game 2: ends at 15, high stays 27.
    startGame(8'h27);
    playCountdown(8'h15, -1);
    checkOutput("high_after_15", 16'({high_BCD1, high_BCD0}), 16'h27);

    // Game 3: ends at 42 (tens digit larger, ones digit smaller than 27).
    startGame(8'h27);
    playCountdown(8'h42, -1);
    checkOutput("high_after_42", 16'({high_BCD1, high_BCD0}), 16'h42);
    step();
    step();
    checkOutput("high_equal_42", 16'({high_BCD1, high_BCD0}), 16'h42);
    applyStimulus(8'h39);
    step();
    step();
    checkOutput("high_lower_39", 16'({high_BCD1, high_BCD0}), 16'h42);

    // Game 4: reset when the display reads 07.
    startGame(8'h42);
    for (int k = 0; k < 20; k++) step();
    checkOutput("pre_reset_time", 16'({time_BCD1, time_BCD0}), 16'h07);
    checkOutput("pre_reset_playing", 16'(playing), 16'h1);
    reset = 1'b1;
    step();
    checkOutput("midreset_playing", 16'(playing), 16'h0);
    checkOutput("midreset_timesup", 16'(timesup), 16'h1);
    checkOutput("midreset_time", 16'({time_BCD1, time_BCD0}), 16'h12);
    checkOutput("midreset_high", 16'({high_BCD1, high_BCD0}), 16'h00);
    checkOutput("midreset_random", 16'(random), 16'h1);
    checkOutput("midreset_core_reset_n", 16'(core_reset_n), 16'h0);
    reset = 1'b0;
    step();
    checkOutput("postreset_random", 16'(random), 16'h3);
    checkOutput("postreset_idle", 16'(playing), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/whac_game_ctrl.md
Name: whac_game_ctrl

Overview:
Game-level sequencer for the whack-a-mole core.
- Runs the round: idle → core clear → timed play → game over.
- Drives the core's `timesup` and `random` inputs, and its active-low reset.
- Provides a BCD countdown for the time display.
- Tracks the high score from the core's BCD score outputs.

Parameters:
- TICKS_PER_SEC, 1000000, `clk_1us` cycles per game second (≤ 2^20; tick counter is 20 bits).
- GAME_TENS, 3, tens digit of game length in seconds (BCD, 0-9).
- GAME_ONES, 0, ones digit of game length (BCD, 0-9); GAME_TENS:GAME_ONES must be ≥ 01.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk_1us  in  1  system clock, 1 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  debounced start button, level.
- score_BCD1  in  4  core score, tens digit.
- score_BCD0  in  4  core score, ones digit.
- timesup  out  1  to core; 1 = hits and new moles blocked.
- random  out  4  to core; mole position candidate.
- core_reset_n  out  1  to core's active-low reset.
- playing  out  1  1 while in PLAY.
- time_BCD1  out  4  remaining seconds, tens digit.
- time_BCD0  out  4  remaining seconds, ones digit.
- high_BCD1  out  4  high score, tens digit.
- high_BCD0  out  4  high score, ones digit.

Behaviour:
- All registers update on posedge `clk_1us`; `reset` is sampled only at the edge.
- **Reset values:**
  - state = IDLE; time = GAME_TENS:GAME_ONES; tick = 0.
  - high = 00; lfsr = LFSR_SEED; start_q = 1.
  - start_q = 1 means a button held through reset does not start a game.
- **Start detect:** start_pulse = start & ~start_q (combinational); start_q <= start every cycle.
- **States (2-bit):** IDLE, ARM, PLAY, OVER.
  - IDLE: on start_pulse → ARM.
  - ARM: exactly 1 cycle; load time = GAME_TENS:GAME_ONES and tick = 0; → PLAY.
  - PLAY:
    - tick increments each cycle.
    - When tick == TICKS_PER_SEC-1: tick <= 0 and time decrements by one BCD step.
    - If time == 01 at that edge: time <= 00 and state → OVER on the same edge.
    - start is ignored in PLAY.
  - OVER: time holds 00; on start_pulse → ARM (new game, high score kept).
  - Unused state encoding → IDLE.
- **BCD decrement:** if ones == 0 then ones <= 9 and tens <= tens-1; else ones <= ones-1. Never decrements below 00.
- **PLAY duration:** exactly (10*GAME_TENS+GAME_ONES)*TICKS_PER_SEC cycles.
- **Output decodes:**
  - timesup = (state != PLAY), combinational. A core hit in the last PLAY cycle still counts.
  - playing = (state == PLAY).
  - core_reset_n = ~(reset | state == ARM), combinational. This clears the core score for one cycle at each game start; the score is not cleared in IDLE or OVER.
- **High score:**
  - In OVER, every cycle: if {score_BCD1,score_BCD0} > {high_BCD1,high_BCD0}, high <= score.
  - Compare as 8-bit unsigned; BCD ordering is preserved. The score is frozen in OVER because timesup = 1.
  - Equal scores: no change.
- **LFSR:**
  - 16-bit Fibonacci, advances every cycle in all states.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - random = lfsr[3:0].
- **Reset mid-game:** immediate return to reset values, including high = 00. core_reset_n is low for the reset cycles.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, GAME_TENS=1, GAME_ONES=2.
1. Hold reset 2 cycles, start=0 → during reset: core_reset_n=0. After release: IDLE, timesup=1, playing=0, time=12, high=00, random=4'h1. One cycle later: lfsr=16'h59C3, random=4'h3.
2. Release reset with start=1 held, keep it high 20 cycles → stays IDLE. Drop start, then raise it → ARM next cycle with core_reset_n=0 for exactly 1 cycle, then PLAY with timesup=0 and time=12.
3. Run PLAY → time reads 12,11,10,09,…,01 with steps every 4 cycles (borrow 10→09 checked). After exactly 48 PLAY cycles: OVER, time=00, timesup=1.
4. score=27 at game end → high=27. Next game ending at score=15 → high stays 27. Next game ending at score=42 → high=42. Score 42 vs high 42 → unchanged.
5. Pulse start mid-PLAY → ignored, countdown unaffected. Pulse start in OVER → ARM, time reloads to 12, high retained.
6. Assert reset at PLAY time=07 → next cycle IDLE, time=12, high=00, lfsr=16'hACE1, timesup=1.
